prefetch_unit: RTL and testbench

PREFETCH_UNIT -- requirements
Module: prefetch_unit

---
 rtl/core_pkg.sv | 15 +
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/prefetch_unit.sv | 140 ++++++++++++++
 tb/tb_prefetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Core-wide widths and exception encodings shared by the front end.
package core_pkg;

    localparam int ALEN = 64;
    localparam int ILEN = 32;

    typedef enum logic [3:0] {
        EXC_INSTR_MISALIGNED   = 4'h0,
        EXC_INSTR_ACCESS_FAULT = 4'h1,
        EXC_ILLEGAL_INSTR      = 4'h2,
        EXC_BREAKPOINT         = 4'h3,
        EXC_INSTR_PAGE_FAULT   = 4'hC
    } except_code_t;

endpackage

// File: rtl/fetch_pkg.sv
// Fetch-side types: the instruction buffer entry and the sequential PC step.
package fetch_pkg;
    import core_pkg::*;

    localparam int INSTR_BYTES = 4;

    typedef logic [ILEN-1:0] instr_t;

    typedef struct packed {
        instr_t          instr;
        logic [ALEN-1:0] pc;
        logic            except_raised;
        except_code_t    code;
    } prefetch_entry_t;

    function automatic logic [ALEN-1:0] next_pc(input logic [ALEN-1:0] pc);
        return pc + ALEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction buffer, DEPTH entries of entry_t, synchronous clear.
// Latency: a push is visible at the head on the next cycle; no bypass.
// Backpressure: push while full only succeeds together with a pop.
module fetch_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push,
    input  entry_t                       wdata,
    input  logic                         pop,
    output entry_t                       rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    // Pointers are PTR_W wide with DEPTH a power of two, so they wrap for free.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr && !rst) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: credit-limited in-order memory requests feeding a small issue buffer.
// Latency: response-to-issue 1 cycle; 0 when built with PREFETCH_BYPASS_EN and the buffer is empty.
// Backpressure: requests stop when in-flight plus buffered reach DEPTH, so responses are always accepted.
module prefetch_unit
    import core_pkg::*;
    import fetch_pkg::*;
#(
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [ALEN-1:0] BOOT_PC         = 64'h0
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               redirect_valid_i,
    input  logic [ALEN-1:0]    redirect_pc_i,

    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [ALEN-1:0]    instr_addr_o,

    input  logic               instr_valid_i,
    output logic               instr_ready_o,
    input  logic [ILEN-1:0]    instr_rdata_i,
    input  logic               instr_except_raised_i,
    input  except_code_t       instr_except_code_i,

    output logic               issue_valid_o,
    input  logic               issue_ready_i,
    output logic [ILEN-1:0]    issue_instr_o,
    output logic [ALEN-1:0]    issue_pc_o,
    output logic               issue_except_raised_o,
    output except_code_t       issue_except_code_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int INF_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [INF_W-1:0] MAX_INF = INF_W'(MAX_OUTSTANDING);

    logic [ALEN-1:0]  req_pc;
    logic [ALEN-1:0]  rsp_pc;
    logic [INF_W-1:0] inflight;
    logic [INF_W-1:0] inflight_next;
    logic [INF_W-1:0] drop_cnt;
    logic             halted;
    logic [CNT_W-1:0] count;
    logic [31:0]      credit_used;

    logic             req_fire;
    logic             rsp_fire;
    logic             rsp_keep;
    logic             push;
    logic             pop;

    prefetch_entry_t  rsp_entry;
    prefetch_entry_t  head;
    prefetch_entry_t  issue_sel;

    // Stale responses still owed by memory occupy no buffer slot, hence the drop_cnt discount.
    assign credit_used = 32'(inflight) - 32'(drop_cnt) + 32'(count);

    assign instr_valid_o = !rst_i && !redirect_valid_i && !halted
                           && (inflight < MAX_INF) && (credit_used < 32'(DEPTH));
    assign instr_addr_o  = req_pc;
    assign instr_ready_o = !rst_i;

    assign req_fire = instr_valid_o && instr_ready_i;
    assign rsp_fire = instr_valid_i && instr_ready_o;
    assign rsp_keep = rsp_fire && !redirect_valid_i && (drop_cnt == '0);

    assign inflight_next = inflight + INF_W'(req_fire) - INF_W'(rsp_fire);

    always_comb begin
        rsp_entry               = '0;
        rsp_entry.instr         = instr_rdata_i;
        rsp_entry.pc            = rsp_pc;
        rsp_entry.except_raised = instr_except_raised_i;
        rsp_entry.code          = instr_except_code_i;
    end

`ifdef PREFETCH_BYPASS_EN
    logic bypass;

    assign bypass        = rsp_keep && (count == '0);
    assign push          = rsp_keep && !(bypass && issue_ready_i);
    assign issue_valid_o = !rst_i && ((count != '0) || bypass);
    assign issue_sel     = bypass ? rsp_entry : head;
`else
    assign push          = rsp_keep;
    assign issue_valid_o = !rst_i && (count != '0);
    assign issue_sel     = head;
`endif

    assign pop = issue_valid_o && issue_ready_i && !redirect_valid_i && (count != '0);

    assign issue_instr_o         = issue_sel.instr;
    assign issue_pc_o            = issue_sel.pc;
    assign issue_except_raised_o = issue_sel.except_raised;
    assign issue_except_code_o   = issue_sel.code;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (prefetch_entry_t)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (redirect_valid_i),
        .push  (push),
        .wdata (rsp_entry),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

    // A redirect owes a drop for every request still in flight after this cycle's response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_pc   <= BOOT_PC;
            rsp_pc   <= BOOT_PC;
            inflight <= '0;
            drop_cnt <= '0;
            halted   <= 1'b0;
        end else if (redirect_valid_i) begin
            req_pc   <= redirect_pc_i;
            rsp_pc   <= redirect_pc_i;
            inflight <= inflight_next;
            drop_cnt <= inflight_next;
            halted   <= 1'b0;
        end else begin
            inflight <= inflight_next;
            if (req_fire) req_pc <= next_pc(req_pc);
            if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - INF_W'(1);
            if (rsp_keep) begin
                rsp_pc <= next_pc(rsp_pc);
                if (instr_except_raised_i) halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prefetch_unit.sv
// Scoreboarded bench for prefetch_unit: memory model with epochs, table of redirect segments, corner sequences.
module tb_prefetch_unit;
    import core_pkg::*;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;
    localparam logic [ALEN-1:0] BOOT   = 64'h0;
    localparam logic [ALEN-1:0] NO_EXC = '1;
`ifdef PREFETCH_BYPASS_EN
    localparam int RSP_TO_ISSUE = 0;
`else
    localparam int RSP_TO_ISSUE = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_i;
    logic            redirect_valid_i;
    logic [ALEN-1:0] redirect_pc_i;
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [ALEN-1:0] instr_addr_o;
    logic            instr_valid_i;
    logic            instr_ready_o;
    logic [ILEN-1:0] instr_rdata_i;
    logic            instr_except_raised_i;
    except_code_t    instr_except_code_i;
    logic            issue_valid_o;
    logic            issue_ready_i;
    logic [ILEN-1:0] issue_instr_o;
    logic [ALEN-1:0] issue_pc_o;
    logic            issue_except_raised_o;
    except_code_t    issue_except_code_o;

    always #5 clk = ~clk;

    prefetch_unit #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .BOOT_PC(BOOT)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .redirect_valid_i      (redirect_valid_i),
        .redirect_pc_i         (redirect_pc_i),
        .instr_valid_o         (instr_valid_o),
        .instr_ready_i         (instr_ready_i),
        .instr_addr_o          (instr_addr_o),
        .instr_valid_i         (instr_valid_i),
        .instr_ready_o         (instr_ready_o),
        .instr_rdata_i         (instr_rdata_i),
        .instr_except_raised_i (instr_except_raised_i),
        .instr_except_code_i   (instr_except_code_i),
        .issue_valid_o         (issue_valid_o),
        .issue_ready_i         (issue_ready_i),
        .issue_instr_o         (issue_instr_o),
        .issue_pc_o            (issue_pc_o),
        .issue_except_raised_o (issue_except_raised_o),
        .issue_except_code_o   (issue_except_code_o)
    );

    typedef struct { logic [ALEN-1:0] addr; int epoch; } mreq_t;
    typedef struct { logic [ALEN-1:0] pc; logic [ILEN-1:0] instr; logic exc; except_code_t code; } exp_t;
    typedef struct {
        logic [ALEN-1:0] target;
        int n_req, req_pct, rsp_pct, iss_pct, run;
        int exp_issued;
        logic [ALEN-1:0] exp_last_pc;
    } vec_t;

    mreq_t mem_q[$];
    exp_t  exp_q[$];
    vec_t  vecs[5];

    int n_checks = 0, n_pass = 0, cyc = 0, epoch = 0, n_issued = 0;
    int reqs_done = 0, req_limit = -1, req_pct = 100, rsp_pct = 100, iss_pct = 100;
    int first_rsp_cyc = -1, first_iss_cyc = -1;
    logic [ALEN-1:0] exp_req, exc_addr, last_iss_pc, first_pc, exc_iss_pc;
    bit halted_exp = 0, want_first = 0;

    function automatic logic [ILEN-1:0] mem_word(input logic [ALEN-1:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Observe the handshakes that complete on the coming rising edge.
    task automatic sample();
        bit    req_f, rsp_f, iss_f;
        mreq_t m;
        exp_t  e;
        req_f = instr_valid_o && instr_ready_i;
        rsp_f = instr_valid_i && instr_ready_o;
        iss_f = issue_valid_o && issue_ready_i;
        if (redirect_valid_i) check("no_req_on_redirect", instr_valid_o, 1'b0);
        if (halted_exp)       check("no_req_while_halted", instr_valid_o, 1'b0);
        if (rsp_f && mem_q.size() > 0) begin
            m = mem_q.pop_front();
            if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
            if (m.epoch == epoch && !redirect_valid_i) begin
                e.pc    = m.addr;
                e.instr = mem_word(m.addr);
                e.exc   = instr_except_raised_i;
                e.code  = instr_except_code_i;
                exp_q.push_back(e);
                if (e.exc) halted_exp = 1;
            end
        end
        if (req_f) begin
            check("req_addr", instr_addr_o, exp_req);
            exp_req = next_pc(exp_req);
            m.addr  = instr_addr_o;
            m.epoch = epoch;
            mem_q.push_back(m);
            reqs_done++;
            check("inflight_le_max", mem_q.size() <= MAXO, 1'b1);
        end
        if (iss_f && !redirect_valid_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL issue_unexpected: pc 0x%0h issued, nothing expected (cycle %0d)", issue_pc_o, cyc);
            end else begin
                e = exp_q.pop_front();
                check("issue_pc", issue_pc_o, e.pc);
                check("issue_instr", issue_instr_o, e.instr);
                check("issue_exc", issue_except_raised_o, e.exc);
                check("issue_code", issue_except_code_o, e.code);
            end
            n_issued++;
            last_iss_pc = issue_pc_o;
            if (issue_except_raised_o) exc_iss_pc = issue_pc_o;
            if (first_iss_cyc < 0) first_iss_cyc = cyc;
            if (want_first) begin first_pc = issue_pc_o; want_first = 0; end
        end
        if (redirect_valid_i) begin
            epoch++;
            exp_q.delete();
            exp_req    = redirect_pc_i;
            halted_exp = 0;
            want_first = 1;
        end
        cyc++;
    endtask

    task automatic drive_inputs();
        if (mem_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
            instr_valid_i         = 1'b1;
            instr_rdata_i         = mem_word(mem_q[0].addr);
            instr_except_raised_i = (mem_q[0].addr == exc_addr);
            instr_except_code_i   = instr_except_raised_i ? EXC_INSTR_ACCESS_FAULT : EXC_INSTR_MISALIGNED;
        end else begin
            instr_valid_i         = 1'b0;
            instr_rdata_i         = '0;
            instr_except_raised_i = 1'b0;
            instr_except_code_i   = EXC_INSTR_MISALIGNED;
        end
        instr_ready_i = (req_limit < 0 || reqs_done < req_limit) && ($urandom_range(99) < req_pct);
        issue_ready_i = ($urandom_range(99) < iss_pct);
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        redirect_valid_i = 1'b0;
        mem_q.delete();
        instr_valid_i = 1'b0;
        repeat (2) begin
            tick();
            check("rst_instr_valid", instr_valid_o, 1'b0);
            check("rst_instr_ready", instr_ready_o, 1'b0);
            check("rst_issue_valid", issue_valid_o, 1'b0);
        end
        rst_i = 1'b0;
        exp_q.delete();
        exp_req = BOOT;
        epoch++;
        halted_exp = 0;
        want_first = 1;
        reqs_done = 0;
        first_rsp_cyc = -1;
        first_iss_cyc = -1;
    endtask

    task automatic wait_issue(input string name, input int budget);
        int start;
        int k;
        start = n_issued;
        k = 0;
        while (n_issued == start && k < budget) begin tick(); k++; end
        if (n_issued == start) timeout(name);
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (!(mem_q.size() == 0 && exp_q.size() == 0
                 && (req_pct == 0 || (req_limit >= 0 && reqs_done >= req_limit))) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) timeout(name);
    endtask

    initial begin
        int start;
        vecs[0] = '{64'h1000, 6, 100, 100, 100, 20, 6, 64'h1014};
        vecs[1] = '{64'h2000, 9,  50,  60,  40, 30, 9, 64'h2020};
        vecs[2] = '{64'h0040, 8, 100, 100,   0, 20, 8, 64'h005C};
        vecs[3] = '{64'hFFF0, 5,  70, 100, 100, 10, 5, 64'h10000};
        vecs[4] = '{64'h0080, 1, 100,  30, 100,  5, 1, 64'h0080};

        rst_i = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0;
        instr_ready_i = 1'b0; instr_valid_i = 1'b0; instr_rdata_i = '0;
        instr_except_raised_i = 1'b0; instr_except_code_i = EXC_INSTR_MISALIGNED;
        issue_ready_i = 1'b0; exc_addr = NO_EXC; exp_req = BOOT;
        last_iss_pc = '0; first_pc = '0; exc_iss_pc = '1;

        // Boot fetch: sequential requests, bounded in-flight, buffer latency.
        do_reset();
        wait_issue("boot_first_issue", 20);
        check("boot_first_pc", first_pc, BOOT);
        check("rsp_to_issue_latency", first_iss_cyc - first_rsp_cyc, RSP_TO_ISSUE);
        repeat (10) tick();

        // Stalled consumer fills the buffer and holds it.
        iss_pct = 0;
        do_reset();
        repeat (12) tick();
        check("full_req_count", reqs_done, 4);
        check("full_no_req", instr_valid_o, 1'b0);
        check("full_issue_valid", issue_valid_o, 1'b1);
        check("full_head_pc", issue_pc_o, 64'h0);
        check("full_buffered", exp_q.size(), 4);
        repeat (20) tick();
        check("hold_req_count", reqs_done, 4);
        check("hold_buffered", exp_q.size(), 4);
        req_pct = 0; iss_pct = 100;
        start = n_issued;
        drain("full_drain", 30);
        check("full_drain_count", n_issued - start, 4);
        check("full_drain_last_pc", last_iss_pc, 64'hC);

        // Redirect with two requests outstanding.
        req_pct = 100; rsp_pct = 0;
        do_reset();
        repeat (3) tick();
        check("two_in_flight", mem_q.size(), 2);
        check("cap_blocks_req", instr_valid_o, 1'b0);
        redirect_valid_i = 1'b1; redirect_pc_i = 64'h1000;
        tick();
        redirect_valid_i = 1'b0;
        rsp_pct = 100;
        wait_issue("redirect_first_issue", 30);
        check("redirect_first_pc", first_pc, 64'h1000);

        // Redirect coinciding with a response.
        rsp_pct = 0;
        do_reset();
        repeat (3) tick();
        rsp_pct = 100;
        drive_inputs();
        redirect_valid_i = 1'b1; redirect_pc_i = 64'h300;
        tick();
        redirect_valid_i = 1'b0;
        wait_issue("coincident_first_issue", 30);
        check("coincident_first_pc", first_pc, 64'h300);

        // Exception on 0x8 halts fetch until a redirect.
        exc_addr = 64'h8;
        do_reset();
        repeat (15) tick();
        check("exc_issued_pc", exc_iss_pc, 64'h8);
        check("halt_req_count", reqs_done, 4);
        check("halt_no_req", instr_valid_o, 1'b0);
        exc_addr = NO_EXC;
        redirect_valid_i = 1'b1; redirect_pc_i = 64'h200;
        tick();
        redirect_valid_i = 1'b0;
        wait_issue("restart_first_issue", 30);
        check("restart_first_pc", first_pc, 64'h200);

        // Table of redirect segments under mixed backpressure.
        req_limit = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            redirect_valid_i = 1'b1;
            redirect_pc_i    = vecs[i].target;
            reqs_done = 0;
            req_limit = vecs[i].n_req;
            req_pct = vecs[i].req_pct; rsp_pct = vecs[i].rsp_pct; iss_pct = vecs[i].iss_pct;
            start = n_issued;
            tick();
            redirect_valid_i = 1'b0;
            repeat (vecs[i].run) tick();
            req_pct = 100; rsp_pct = 100; iss_pct = 100;
            drain("row_drain", 300);
            check("row_issued", n_issued - start, vecs[i].exp_issued);
            check("row_last_pc", last_iss_pc, vecs[i].exp_last_pc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
